// File: rtl/fsm_mealy_param.sv
// One component of a decomposed free-choice Petri net: one-hot places, barrier-gated
// Mealy transitions. Define FSM_MEALY_RR_ARB_EN for round-robin conflict arbitration.
module fsm_mealy_param #(
  parameter int                        N_PLACES   = 4,
  parameter int                        N_TRANS    = 5,
  parameter int                        N_TB       = 2,
  parameter int                        INIT_PLACE = 2,
  parameter logic [8*N_TRANS-1:0]      TRANS_SRC  = 40'h01_00_03_02_02,
  parameter logic [8*N_TRANS-1:0]      TRANS_DST  = 40'h03_03_02_01_00,
  parameter logic [N_TRANS*N_TB-1:0]   TB_MASK    = 10'h17F
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_TRANS-1:0]        t_req,
  input  logic [N_TRANS*N_TB-1:0]   tb,
  output logic [N_PLACES-1:0]       place,
  output logic [N_TRANS-1:0]        fire,
  output logic                      err
);

  localparam logic [N_PLACES-1:0] ONE_P       = {{(N_PLACES-1){1'b0}}, 1'b1};
  localparam logic [N_TRANS-1:0]  ONE_T       = {{(N_TRANS-1){1'b0}}, 1'b1};
  localparam logic [N_PLACES-1:0] INIT_ONEHOT = ONE_P << INIT_PLACE;

  logic [N_PLACES-1:0] place_q, place_d;
  logic                err_q, err_d;
  logic [N_TRANS-1:0]  sync;
  logic [N_TRANS-1:0]  enabled;
  logic [7:0]          dst [N_TRANS];
  logic                legal;
  logic                found;
  int                  sel;

  if (INIT_PLACE >= N_PLACES) begin : g_bad_init
    $error("fsm_mealy_param: INIT_PLACE %0d out of range", INIT_PLACE);
  end

  for (genvar gi = 0; gi < N_TRANS; gi++) begin : g_trans
    localparam int SRC_I = int'(TRANS_SRC[gi*8 +: 8]);
    localparam int DST_I = int'(TRANS_DST[gi*8 +: 8]);

    assign sync[gi] = t_req[gi] & (&(tb[gi*N_TB +: N_TB] | ~TB_MASK[gi*N_TB +: N_TB]));
    assign dst[gi]  = TRANS_DST[gi*8 +: 8];

    if (SRC_I >= N_PLACES) begin : g_bad_src
      $error("fsm_mealy_param: transition %0d source %0d out of range", gi, SRC_I);
      assign enabled[gi] = 1'b0;
    end else begin : g_src
      assign enabled[gi] = sync[gi] & place_q[SRC_I];
    end

    if (DST_I >= N_PLACES) begin : g_bad_dst
      $error("fsm_mealy_param: transition %0d destination %0d out of range", gi, DST_I);
    end
  end

`ifdef FSM_MEALY_RR_ARB_EN
  localparam int PW = (N_TRANS > 1) ? $clog2(N_TRANS) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  int            idx;
`endif

  always_comb begin
    place_d = place_q;
    err_d   = err_q;
    fire    = '0;
    found   = 1'b0;
    sel     = 0;
    legal   = $onehot(place_q);
`ifdef FSM_MEALY_RR_ARB_EN
    ptr_d   = ptr_q;
    idx     = 0;
    // Search wraps upward starting at the highest-priority index.
    for (int off = 0; off < N_TRANS; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_TRANS) idx = idx - N_TRANS;
      if (!found && enabled[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
`else
    for (int i = N_TRANS - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        found = 1'b1;
        sel   = i;
      end
    end
`endif
    if (!legal) begin
      place_d = INIT_ONEHOT;
      err_d   = 1'b1;
    end else if (found && reset) begin
      fire    = ONE_T << sel;
      place_d = ONE_P << dst[sel];
`ifdef FSM_MEALY_RR_ARB_EN
      ptr_d   = PW'((sel + 1) % N_TRANS);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      place_q <= INIT_ONEHOT;
      err_q   <= 1'b0;
`ifdef FSM_MEALY_RR_ARB_EN
      ptr_q   <= '0;
`endif
    end else begin
      place_q <= place_d;
      err_q   <= err_d;
`ifdef FSM_MEALY_RR_ARB_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign place = place_q;
  assign err   = err_q;

endmodule
